// File: rtl/lp805x_synctrl_mc.sv
// ---------------------------------------------------------------------------
// lp805x_synctrl_mc
// Multi-channel SFR transfer controller for lp805x peripherals.
//
// A channel becomes ARMED and raises its get strobe when its peripheral reports
// read-ready. It issues a one-cycle put pulse after the CPU reads it. A channel
// that stays ARMED too long is recovered by a timeout, which also sets a sticky
// error flag. The CPU-side strobes are resynchronised into clk.
//
// Ports
//   clk, rst      clock; synchronous active-high reset
//   prrdy[NCH]    peripheral read-ready, one bit per channel
//   pwrdy[NCH]    peripheral write-ready, one bit per channel
//   pget[NCH]     get strobe; held high while the channel is ARMED
//   pput[NCH]     put pulse; high for exactly one clk
//   read          SFR read cycle in progress (clk domain)
//   sel[NCH]      channel select from the SFR decode
//   cpu_rrdy      CPU read-ready, asynchronous to clk
//   cpu_get       CPU get request, asynchronous to clk
//   sfr_out       qualified CPU get, registered
//   busy          high while any channel is not IDLE, registered
//   err           sticky timeout flag
//   err_ch        index of the last channel that timed out
//   err_clr       clears err; err_ch is retained
// ---------------------------------------------------------------------------
module lp805x_synctrl_mc #(
  parameter int NCH         = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 15,
  parameter int TW          = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] prrdy,
  input  logic [NCH-1:0] pwrdy,
  output logic [NCH-1:0] pget,
  output logic [NCH-1:0] pput,
  input  logic           read,
  input  logic [NCH-1:0] sel,
  input  logic           cpu_rrdy,
  input  logic           cpu_get,
  output logic           sfr_out,
  output logic           busy,
  output logic           err,
  output logic [3:0]     err_ch,
  input  logic           err_clr
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_PUT   = 2'd2
  } state_e;

  // Last count value before the timeout fires; irrelevant when TIMEOUT is 0.
  localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [TW-1:0] CNT_MAX = {TW{1'b1}};

  state_e          state_q [NCH];
  state_e          state_d [NCH];
  logic [TW-1:0]   cnt_q   [NCH];
  logic [TW-1:0]   cnt_d   [NCH];

  logic [NCH-1:0]  qual;
  logic [NCH-1:0]  win;
  logic [NCH-1:0]  tmo;
  logic            found;

  logic [NCH-1:0]  pput_q, pput_d;
  logic            busy_q, busy_d;
  logic            err_q, err_d;
  logic [3:0]      err_ch_q, err_ch_d;

  logic [SYNC_STAGES-1:0] rrdy_sync_q;
  logic [SYNC_STAGES-1:0] get_sync_q;
  logic                   rrdy_s;
  logic                   get_s;
  logic                   this_q;
  logic                   sfr_out_q;

  // Get strobe is a decode of the ARMED state register.
  always_comb begin
    pget = '0;
    for (int i = 0; i < NCH; i++) begin
      pget[i] = (state_q[i] == ST_ARMED);
    end
  end

  // Transfer qualification and fixed-priority arbitration: lowest index wins.
  always_comb begin
    qual  = pget & pwrdy & {NCH{read}} & sel;
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (qual[i] && !found) begin
        win[i] = 1'b1;
        found  = 1'b1;
      end else begin
        win[i] = 1'b0;
      end
    end
  end

  // Per-channel next state; a fresh read-ready re-arms and overrides everything.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      tmo[i]     = 1'b0;
      if (prrdy[i]) begin
        state_d[i] = ST_ARMED;
        cnt_d[i]   = '0;
      end else begin
        case (state_q[i])
          ST_ARMED: begin
            if (win[i]) begin
              state_d[i] = ST_PUT;
            end else if ((TIMEOUT != 0) && (cnt_q[i] == TO_LAST)) begin
              state_d[i] = ST_IDLE;
              tmo[i]     = 1'b1;
            end else if (cnt_q[i] != CNT_MAX) begin
              cnt_d[i] = cnt_q[i] + TW'(1);
            end else begin
              cnt_d[i] = cnt_q[i];
            end
          end
          ST_PUT:  state_d[i] = ST_IDLE;
          ST_IDLE: state_d[i] = ST_IDLE;
          default: state_d[i] = ST_IDLE;
        endcase
      end
    end
  end

  // Put pulse, busy and error bookkeeping; ascending scan leaves the highest
  // timed-out index in err_ch, and a new timeout beats err_clr.
  always_comb begin
    pput_d   = '0;
    busy_d   = 1'b0;
    err_ch_d = err_ch_q;
    for (int i = 0; i < NCH; i++) begin
      pput_d[i] = (state_q[i] == ST_PUT);
      if (state_q[i] != ST_IDLE) begin
        busy_d = 1'b1;
      end else begin
        busy_d = busy_d;
      end
      if (tmo[i]) begin
        err_ch_d = 4'(i);
      end else begin
        err_ch_d = err_ch_d;
      end
    end
    if (|tmo) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // Channel, status and error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
      end
      pput_q   <= '0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      err_ch_q <= 4'd0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      pput_q   <= pput_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      err_ch_q <= err_ch_d;
    end
  end

  assign rrdy_s = rrdy_sync_q[SYNC_STAGES-1];
  assign get_s  = get_sync_q[SYNC_STAGES-1];

  // CPU-side synchronisers plus one qualifying register stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      rrdy_sync_q <= '0;
      get_sync_q  <= '0;
      this_q      <= 1'b0;
      sfr_out_q   <= 1'b0;
    end else begin
      rrdy_sync_q <= {rrdy_sync_q[SYNC_STAGES-2:0], cpu_rrdy};
      get_sync_q  <= {get_sync_q[SYNC_STAGES-2:0], cpu_get};
      this_q      <= rrdy_s;
      sfr_out_q   <= get_s & this_q;
    end
  end

  assign pput    = pput_q;
  assign busy    = busy_q;
  assign err     = err_q;
  assign err_ch  = err_ch_q;
  assign sfr_out = sfr_out_q;

endmodule

// File: tb/tb_lp805x_synctrl_mc.sv
// ---------------------------------------------------------------------------
// tb_lp805x_synctrl_mc
// Self-checking bench for lp805x_synctrl_mc: directed scenarios followed by
// random stimulus, every cycle compared against a behavioural model.
// ---------------------------------------------------------------------------
module tb_lp805x_synctrl_mc;

  localparam int NCH = 4;
  localparam int S   = 2;
  localparam int TO  = 15;
  localparam int TW  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst = 1'b1;
  logic [NCH-1:0] prrdy = '0, pwrdy = '0, sel = '0;
  logic [NCH-1:0] pget, pput;
  logic           read = 1'b0, cpu_rrdy = 1'b0, cpu_get = 1'b0, err_clr = 1'b0;
  logic           sfr_out, busy, err;
  logic [3:0]     err_ch;

  lp805x_synctrl_mc #(.NCH(NCH), .SYNC_STAGES(S), .TIMEOUT(TO), .TW(TW)) dut (
    .clk(clk), .rst(rst), .prrdy(prrdy), .pwrdy(pwrdy), .pget(pget), .pput(pput),
    .read(read), .sel(sel), .cpu_rrdy(cpu_rrdy), .cpu_get(cpu_get),
    .sfr_out(sfr_out), .busy(busy), .err(err), .err_ch(err_ch), .err_clr(err_clr)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Behavioural model: each channel is "waiting" (armed, with an age in
  // cycles) or "handing over"; CPU path is a sample history.
  bit             m_armed [NCH];
  bit             m_xfer  [NCH];
  int             m_age   [NCH];
  bit [NCH-1:0]   m_pput;
  bit             m_busy, m_err, m_sfr;
  int             m_errch;
  bit             m_gh [S+2];
  bit             m_rh [S+2];

  function automatic logic [NCH-1:0] m_pget();
    logic [NCH-1:0] v = '0;
    for (int i = 0; i < NCH; i++) v[i] = m_armed[i];
    return v;
  endfunction

  task automatic model_edge();
    int  winner;
    bit  any_to;
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        m_armed[i] = 0; m_xfer[i] = 0; m_age[i] = 0;
      end
      for (int k = 0; k < S + 2; k++) begin
        m_gh[k] = 0; m_rh[k] = 0;
      end
      m_pput = '0; m_busy = 0; m_err = 0; m_errch = 0; m_sfr = 0;
      return;
    end
    winner = -1;
    for (int i = NCH - 1; i >= 0; i--)
      if (m_armed[i] && pwrdy[i] && read && sel[i]) winner = i;
    m_busy = 0;
    for (int i = 0; i < NCH; i++) begin
      m_pput[i] = m_xfer[i];
      if (m_armed[i] || m_xfer[i]) m_busy = 1;
    end
    any_to = 0;
    for (int i = 0; i < NCH; i++) begin
      if (prrdy[i]) begin
        m_armed[i] = 1; m_age[i] = 0; m_xfer[i] = 0;
      end else if (m_armed[i] && i == winner) begin
        m_armed[i] = 0; m_xfer[i] = 1;
      end else if (m_armed[i] && TO != 0 && m_age[i] + 1 == TO) begin
        m_armed[i] = 0; any_to = 1; m_errch = i;
      end else if (m_armed[i]) begin
        if (m_age[i] < (1 << TW) - 1) m_age[i]++;
      end else begin
        m_xfer[i] = 0;
      end
    end
    if (any_to) m_err = 1;
    else if (err_clr) m_err = 0;
    for (int k = S + 1; k > 0; k--) begin
      m_gh[k] = m_gh[k-1]; m_rh[k] = m_rh[k-1];
    end
    m_gh[0] = cpu_get; m_rh[0] = cpu_rrdy;
    // sfr_out after this edge: get sampled S edges ago, rrdy sampled S+1 ago
    m_sfr = m_gh[S] & m_rh[S+1];
  endtask

  task automatic compare_all();
    check("pget",    pget,    m_pget());
    check("pput",    pput,    m_pput);
    check("busy",    busy,    m_busy);
    check("err",     err,     m_err);
    check("err_ch",  err_ch,  m_errch[3:0]);
    check("sfr_out", sfr_out, m_sfr);
    check("pput_1hot", ($countones(pput) <= 1), 1'b1);
  endtask

  // Apply inputs for one clock, advance the model, compare after the edge.
  task automatic cycle(input logic [NCH-1:0] pr, input logic [NCH-1:0] pw,
                       input logic [NCH-1:0] sl, input logic rd, input logic rr,
                       input logic gt, input logic clr, input logic rs);
    prrdy = pr; pwrdy = pw; sel = sl; read = rd;
    cpu_rrdy = rr; cpu_get = gt; err_clr = clr; rst = rs;
    model_edge();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle('0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset state
    cycle('0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle('0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_pget", pget, 4'b0000);
    check("rst_busy", busy, 1'b0);
    idle(2);

    // Single channel transfer on ch1
    cycle(4'b0010, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t1_pget", pget, 4'b0010);
    idle(2);
    cycle('0, 4'b0010, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t1_pget_drop", pget, 4'b0000);
    check("t1_no_pput_yet", pput, 4'b0000);
    idle(1);
    check("t1_pput", pput, 4'b0010);
    idle(1);
    check("t1_pput_end", pput, 4'b0000);
    idle(2);

    // Two contending channels, lower index first
    cycle(4'b0101, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) cycle('0, 4'b1111, 4'b0101, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);

    // Timeout on ch3, then clear
    cycle(4'b1000, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(TO - 1);
    check("t3_pget_held", pget, 4'b1000);
    idle(1);
    check("t3_pget_drop", pget, 4'b0000);
    check("t3_err", err, 1'b1);
    check("t3_err_ch", err_ch, 4'd3);
    cycle('0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t3_clr", err, 1'b0);
    check("t3_ch_kept", err_ch, 4'd3);

    // CPU path: rrdy stable, 4-cycle get pulse; then rrdy low
    for (int k = 0; k < 4; k++) cycle('0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) cycle('0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) cycle('0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) cycle('0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(4);

    // Reset while ch1 is in PUT
    cycle(4'b0010, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle('0, 4'b0010, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle('0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t5_pput", pput, 4'b0000);
    check("t5_busy", busy, 1'b0);
    idle(3);
    check("t5_no_late_pput", pput, 4'b0000);

    // Re-arm coinciding with qualification on ch0
    cycle(4'b0001, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(4'b0001, 4'b0001, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t6_armed", pget, 4'b0001);
    idle(2);
    check("t6_no_pput", pput, 4'b0000);
    idle(TO);

    // Random traffic; every third block of 200 cycles has no reads so
    // timeouts occur
    for (int k = 0; k < 1800; k++) begin
      logic [NCH-1:0] pr, pw, sl;
      logic rd, rr, gt, clr, rs;
      for (int i = 0; i < NCH; i++) pr[i] = ($urandom_range(0, 11) == 0);
      pw  = NCH'($urandom);
      sl  = ($urandom_range(0, 1) == 0) ? NCH'(1 << $urandom_range(0, NCH - 1)) : NCH'($urandom);
      rd  = ((k / 200) % 3 == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      rr  = ($urandom_range(0, 3) != 0);
      gt  = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 15) == 0);
      rs  = ($urandom_range(0, 299) == 0);
      cycle(pr, pw, sl, rd, rr, gt, clr, rs);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
